// File: rtl/tcdm_responder_banked.sv
// ---------------------------------------------------------------------------
// tcdm_responder_banked
//
// Multi-port, word-interleaved TCDM slave memory. It is the responder end of
// the hwpe_stream TCDM protocol and serves as a shared L1 model behind HWPE
// streamers. Each bank has its own round-robin arbiter. A granted request is
// served by a single-cycle SRAM access, and the response is returned exactly
// one cycle later.
//
// Ports
//   clk_i           clock
//   rst_ni          synchronous active-low reset (memory contents are kept)
//   clear_i         soft clear of the arbiters and response registers
//   tcdm_req_i      per-port request
//   tcdm_gnt_o      per-port grant, combinational, same cycle as req
//   tcdm_add_i      per-port byte address (NP x 32)
//   tcdm_wen_i      per-port 1 = read, 0 = write
//   tcdm_be_i       per-port byte enables for writes (NP x 4)
//   tcdm_data_i     per-port write data (NP x 32)
//   tcdm_r_data_o   per-port read data (NP x 32), held while r_valid is low
//   tcdm_r_valid_o  per-port one-cycle response pulse
//   stall_mask_i    per-port grant inhibit, used for backpressure tests
// ---------------------------------------------------------------------------
module tcdm_responder_banked #(
    parameter int NP    = 4,
    parameter int NB    = 8,
    parameter int DEPTH = 256
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic [NP-1:0]     tcdm_req_i,
    output logic [NP-1:0]     tcdm_gnt_o,
    input  logic [NP*32-1:0]  tcdm_add_i,
    input  logic [NP-1:0]     tcdm_wen_i,
    input  logic [NP*4-1:0]   tcdm_be_i,
    input  logic [NP*32-1:0]  tcdm_data_i,
    output logic [NP*32-1:0]  tcdm_r_data_o,
    output logic [NP-1:0]     tcdm_r_valid_o,
    input  logic [NP-1:0]     stall_mask_i
);

    localparam int BW = $clog2(NB);
    localparam int RW = $clog2(DEPTH);
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;

    logic [BW-1:0] port_bank [NP];
    logic [RW-1:0] port_row  [NP];
    logic [NP-1:0] eligible;
    logic [NP-1:0] gnt;

    logic [PW-1:0] rr_ptr    [NB];
    logic [NB-1:0] bank_hit;
    logic [PW-1:0] bank_port [NB];

    logic [NB-1:0] bank_we;
    logic [RW-1:0] bank_row   [NB];
    logic [3:0]    bank_be    [NB];
    logic [31:0]   bank_wdata [NB];

    logic [31:0]   mem [NB][DEPTH];

    // Only the bank and row fields of the address are decoded. Byte offset
    // bits and the bits above the row are ignored, so high rows alias.
    logic unused_add;
    assign unused_add = ^tcdm_add_i;

    // Word-interleaved address decode. Consecutive words go to consecutive
    // banks, and the row wraps modulo DEPTH.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            port_bank[p] = tcdm_add_i[p*32+2 +: BW];
            port_row[p]  = tcdm_add_i[p*32+2+BW +: RW];
        end
    end

    // Grants are suppressed while reset or a soft clear is active. A request
    // accepted in such a cycle would lose its response anyway.
    assign eligible = tcdm_req_i & ~stall_mask_i & {NP{rst_ni & ~clear_i}};

    // Per-bank round-robin search that starts at the bank's pointer. The first
    // eligible port aimed at this bank wins. Each port targets exactly one
    // bank, so no port can be granted twice.
    always_comb begin
        int idx;
        gnt      = '0;
        bank_hit = '0;
        idx      = 0;
        for (int b = 0; b < NB; b++) begin
            bank_port[b] = '0;
            for (int k = 0; k < NP; k++) begin
                idx = (int'(rr_ptr[b]) + k) % NP;
                if (!bank_hit[b] && eligible[idx] && (port_bank[idx] == BW'(b))) begin
                    bank_hit[b]  = 1'b1;
                    bank_port[b] = PW'(idx);
                    gnt[idx]     = 1'b1;
                end
            end
        end
    end

    assign tcdm_gnt_o = gnt;

    // Route the winning port's write command to each bank.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            bank_we[b]    = bank_hit[b] & ~tcdm_wen_i[bank_port[b]];
            bank_row[b]   = port_row[bank_port[b]];
            bank_be[b]    = tcdm_be_i[bank_port[b]*4 +: 4];
            bank_wdata[b] = tcdm_data_i[bank_port[b]*32 +: 32];
        end
    end

    // Byte-lane SRAM write. This storage has no reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_we[b]) begin
                for (int i = 0; i < 4; i++) begin
                    if (bank_be[b][i]) begin
                        mem[b][bank_row[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
                    end
                end
            end
        end
    end

    // Response registers and round-robin pointers. Reads capture the word as
    // it was before this edge; writes answer with zero data. Each bank serves
    // one access per cycle, so a read never collides with a write to the same
    // word in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tcdm_r_valid_o <= '0;
            tcdm_r_data_o  <= '0;
            for (int b = 0; b < NB; b++) begin
                rr_ptr[b] <= '0;
            end
        end else if (clear_i) begin
            tcdm_r_valid_o <= '0;
            for (int b = 0; b < NB; b++) begin
                rr_ptr[b] <= '0;
            end
        end else begin
            tcdm_r_valid_o <= gnt;
            for (int p = 0; p < NP; p++) begin
                if (gnt[p]) begin
                    tcdm_r_data_o[p*32 +: 32] <= tcdm_wen_i[p] ? mem[port_bank[p]][port_row[p]] : '0;
                end
            end
            for (int b = 0; b < NB; b++) begin
                if (bank_hit[b]) begin
                    rr_ptr[b] <= PW'((int'(bank_port[b]) + 1) % NP);
                end
            end
        end
    end

endmodule

// File: tb/tb_tcdm_responder_banked.sv
// ---------------------------------------------------------------------------
// tb_tcdm_responder_banked
//
// Self-checking bench for tcdm_responder_banked. A word-level memory model
// and per-port response queues act as the scoreboard. Expected read data is
// pushed when a grant is seen and popped when r_valid arrives. Arbitration is
// checked through properties: grants need requests, each bank grants exactly
// one port when any port contends, and every port is served within NP cycles.
// ---------------------------------------------------------------------------
module tb_tcdm_responder_banked;

    localparam int NP    = 4;
    localparam int NB    = 8;
    localparam int DEPTH = 256;
    localparam int WORDS = NB * DEPTH;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              clear;
    logic [NP-1:0]     req;
    logic [NP-1:0]     gnt;
    logic [NP*32-1:0]  add;
    logic [NP-1:0]     wen;
    logic [NP*4-1:0]   be;
    logic [NP*32-1:0]  wdata;
    logic [NP*32-1:0]  r_data;
    logic [NP-1:0]     r_valid;
    logic [NP-1:0]     stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [WORDS];
    logic [31:0] sb_q  [NP][$];
    logic        mon_en = 1'b0;
    logic [NP-1:0] last_gnt;

    always #5 clk = ~clk;

    tcdm_responder_banked #(.NP(NP), .NB(NB), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .clear_i       (clear),
        .tcdm_req_i    (req),
        .tcdm_gnt_o    (gnt),
        .tcdm_add_i    (add),
        .tcdm_wen_i    (wen),
        .tcdm_be_i     (be),
        .tcdm_data_i   (wdata),
        .tcdm_r_data_o (r_data),
        .tcdm_r_valid_o(r_valid),
        .stall_mask_i  (stall)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int p, input logic [31:0] a, input logic w,
                                 input logic [3:0] b, input logic [31:0] d);
        add[p*32 +: 32] = a;
        wen[p]          = w;
        be[p*4 +: 4]    = b;
        wdata[p*32 +: 32] = d;
        req[p]          = 1'b1;
    endtask

    task automatic idle();
        req   = '0;
        clear = 1'b0;
        stall = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int wordOf(input logic [31:0] a);
        logic [29:0] w;
        w = a[31:2];
        return int'(w) % WORDS;
    endfunction

    function automatic int bankOf(input logic [31:0] a);
        logic [29:0] w;
        w = a[31:2];
        return int'(w) % NB;
    endfunction

    // Scoreboard monitor: runs at every falling edge once reset has been
    // checked.
    initial begin
        logic          prev_rst;
        logic [NP-1:0] exp_rv;
        logic [31:0]   last_rdata [NP];
        int            wait_cnt   [NP];
        wait (mon_en);
        prev_rst = 1'b0;
        exp_rv   = '0;
        for (int p = 0; p < NP; p++) begin
            last_rdata[p] = '0;
            wait_cnt[p]   = 0;
        end
        forever begin
            @(negedge clk);
            checkOutput("rvalid", 32'(r_valid), 32'(exp_rv));
            for (int p = 0; p < NP; p++) begin
                if (r_valid[p]) begin
                    if (sb_q[p].size() == 0) begin
                        checkOutput($sformatf("sb_extra_p%0d", p), 32'd1, 32'd0);
                    end else begin
                        checkOutput($sformatf("rdata_p%0d", p), r_data[p*32 +: 32], sb_q[p].pop_front());
                    end
                    last_rdata[p] = r_data[p*32 +: 32];
                end else begin
                    if (!prev_rst) last_rdata[p] = '0;
                    checkOutput($sformatf("rdata_hold_p%0d", p), r_data[p*32 +: 32], last_rdata[p]);
                end
            end
            exp_rv = '0;
            if (rst_ni) begin
                checkOutput("gnt_no_req", 32'(gnt & ~(req & ~stall)), 32'd0);
                if (clear) begin
                    checkOutput("gnt_clear", 32'(gnt), 32'd0);
                    for (int p = 0; p < NP; p++) wait_cnt[p] = 0;
                end else begin
                    for (int b = 0; b < NB; b++) begin
                        int n;
                        int any;
                        n   = 0;
                        any = 0;
                        for (int p = 0; p < NP; p++) begin
                            if (bankOf(add[p*32 +: 32]) == b) begin
                                if (req[p] && !stall[p]) any = 1;
                                if (gnt[p]) n++;
                            end
                        end
                        checkOutput($sformatf("bank_gnt_b%0d", b), 32'(n), 32'(any));
                    end
                    for (int p = 0; p < NP; p++) begin
                        if (req[p] && !stall[p]) begin
                            if (gnt[p]) begin
                                checkOutput($sformatf("rr_wait_p%0d", p), 32'(wait_cnt[p] < NP), 32'd1);
                                wait_cnt[p] = 0;
                            end else begin
                                wait_cnt[p]++;
                            end
                        end else begin
                            wait_cnt[p] = 0;
                        end
                        if (gnt[p]) begin
                            int w;
                            w = wordOf(add[p*32 +: 32]);
                            exp_rv[p] = 1'b1;
                            if (wen[p]) begin
                                sb_q[p].push_back(model[w]);
                            end else begin
                                sb_q[p].push_back(32'd0);
                                for (int i = 0; i < 4; i++) begin
                                    if (be[p*4+i]) model[w][i*8 +: 8] = wdata[p*32+i*8 +: 8];
                                end
                            end
                        end
                    end
                end
            end
            prev_rst = rst_ni;
        end
    end

    // Directed scenarios followed by constrained-random traffic.
    initial begin
        for (int i = 0; i < WORDS; i++) model[i] = '0;
        rst_ni = 1'b0;
        clear  = 1'b0;
        req    = '0;
        add    = '0;
        wen    = '0;
        be     = '0;
        wdata  = '0;
        stall  = '0;
        last_gnt = '0;

        // Reset state after two clocks of reset.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rvalid", 32'(r_valid), 32'd0);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        for (int p = 0; p < NP; p++) checkOutput($sformatf("rst_rdata_p%0d", p), r_data[p*32 +: 32], 32'd0);
        mon_en = 1'b1;
        rst_ni = 1'b1;

        // Fill words 0..63. Four ports write to four distinct banks each cycle.
        for (int i = 0; i < 16; i++) begin
            for (int p = 0; p < NP; p++) applyStimulus(p, 32'((4*i + p) * 4), 1'b0, 4'hF, $urandom());
            @(negedge clk);
            checkOutput("init_gnt", 32'(gnt), 32'hF);
            nextCycle();
        end
        idle();

        // Write followed by a read of the same word on the next cycle.
        applyStimulus(0, 32'h40, 1'b0, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("t2_wr_gnt", 32'(gnt), 32'h1);
        nextCycle();
        applyStimulus(0, 32'h40, 1'b1, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("t2_rd_gnt", 32'(gnt), 32'h1);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t2_rd_valid", 32'(r_valid), 32'h1);
        checkOutput("t2_rd_data", r_data[31:0], 32'hDEADBEEF);
        nextCycle();

        // Byte enables: lanes 0 and 2 update. An all-zero enable is a no-op.
        applyStimulus(0, 32'h8, 1'b0, 4'hF, 32'h11223344);
        nextCycle();
        applyStimulus(0, 32'h8, 1'b0, 4'b0101, 32'hAABBCCDD);
        nextCycle();
        applyStimulus(0, 32'h8, 1'b0, 4'b0000, 32'hFFFFFFFF);
        nextCycle();
        applyStimulus(0, 32'h8, 1'b1, 4'h0, 32'h0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t3_be_data", r_data[31:0], 32'h11BB33DD);
        nextCycle();

        // Soft clear one cycle after a grant. The earlier response still
        // appears, but the request made during the clear is not granted.
        applyStimulus(0, 32'h40, 1'b1, 4'h0, 32'h0);
        nextCycle();
        idle();
        clear = 1'b1;
        applyStimulus(1, 32'h4, 1'b1, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("clr_gnt", 32'(gnt), 32'd0);
        checkOutput("clr_prev_valid", 32'(r_valid), 32'h1);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("clr_rvalid", 32'(r_valid), 32'd0);
        nextCycle();

        // Bank conflict: all four ports read bank 0 and are served in order.
        for (int p = 0; p < NP; p++) applyStimulus(p, 32'(p * 32'h20), 1'b1, 4'h0, 32'h0);
        for (int i = 0; i < NP; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t4_gnt_%0d", i), 32'(gnt), 32'(1 << i));
            checkOutput($sformatf("t4_rvalid_%0d", i), 32'(r_valid), (i == 0) ? 32'd0 : 32'(1 << (i - 1)));
            nextCycle();
            req[i] = 1'b0;
        end
        @(negedge clk);
        checkOutput("t4_rvalid_last", 32'(r_valid), 32'h8);
        nextCycle();
        idle();

        // Parallel access to four distinct banks.
        for (int p = 0; p < NP; p++) applyStimulus(p, 32'(p * 4), 1'b1, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("t5_gnt", 32'(gnt), 32'hF);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t5_rvalid", 32'(r_valid), 32'hF);
        nextCycle();

        // Stall mask holds off the grant. Address 0x2000 aliases word 0.
        applyStimulus(0, 32'h2000, 1'b0, 4'hF, 32'hCAFEF00D);
        stall = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t6_stall_%0d", i), 32'(gnt), 32'd0);
            nextCycle();
        end
        stall = '0;
        @(negedge clk);
        checkOutput("t6_unstall", 32'(gnt), 32'h1);
        nextCycle();
        idle();
        applyStimulus(1, 32'h0, 1'b1, 4'h0, 32'h0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t6_alias", r_data[63:32], 32'hCAFEF00D);
        nextCycle();

        // Reset in the middle of traffic drops any pending response.
        applyStimulus(2, 32'h10, 1'b1, 4'h0, 32'h0);
        nextCycle();
        idle();
        rst_ni = 1'b0;
        applyStimulus(3, 32'h14, 1'b1, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("rstm_prev_valid", 32'(r_valid), 32'h4);
        nextCycle();
        rst_ni = 1'b1;
        idle();
        @(negedge clk);
        checkOutput("rstm_rvalid", 32'(r_valid), 32'd0);
        checkOutput("rstm_rdata", r_data[95:64], 32'd0);
        nextCycle();

        // Random traffic. Masters hold a request until it is granted.
        last_gnt = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            clear = ($urandom_range(0, 49) == 0);
            for (int p = 0; p < NP; p++) begin
                if (req[p] && last_gnt[p]) req[p] = 1'b0;
                if (!req[p] && ($urandom_range(0, 3) != 0)) begin
                    applyStimulus(p,
                        32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3) + 32'h2000 * $urandom_range(0, 2)),
                        1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
                end
            end
            @(negedge clk);
            last_gnt = gnt;
            nextCycle();
        end
        idle();
        repeat (3) nextCycle();
        for (int p = 0; p < NP; p++) checkOutput($sformatf("sb_drain_p%0d", p), 32'(sb_q[p].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
